// File: rtl/upht_update_ctrl_if.sv
// rtl/upht_update_ctrl_if.sv - resolve-record and uPHT write-port bundle for upht_update_ctrl
`ifndef SAT_TABLE_SIZE
`define SAT_TABLE_SIZE 64
`endif

interface upht_update_ctrl_if #(
  parameter int IDX_W      = $clog2(`SAT_TABLE_SIZE),
  parameter int FIFO_DEPTH = 4
);
  logic                          i_resolve_vld;
  logic                          o_resolve_rdy;
  logic [IDX_W-1:0]              i_resolve_idx;
  logic                          i_resolve_taken;
  logic [1:0]                    i_resolve_cnt;
  logic                          i_uPht_enable;
  logic                          o_uPhtWrite_vld;
  logic [IDX_W-1:0]              o_uPhtWr_addr;
  logic [1:0]                    o_commit_Cnt;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt;

  // Commit side plus uPHT side, seen from outside the update stage
  modport master (
    output i_resolve_vld, i_resolve_idx, i_resolve_taken, i_resolve_cnt, i_uPht_enable,
    input  o_resolve_rdy, o_uPhtWrite_vld, o_uPhtWr_addr, o_commit_Cnt, o_fifo_cnt
  );

  // The update stage itself
  modport slave (
    input  i_resolve_vld, i_resolve_idx, i_resolve_taken, i_resolve_cnt, i_uPht_enable,
    output o_resolve_rdy, o_uPhtWrite_vld, o_uPhtWr_addr, o_commit_Cnt, o_fifo_cnt
  );
endinterface

// File: rtl/upht_update_ctrl.sv
// rtl/upht_update_ctrl.sv - uPHT commit update buffer; optional same-index coalescing under UPHT_UPD_COALESCE_EN
`ifndef SAT_TABLE_SIZE
`define SAT_TABLE_SIZE 64
`endif

module upht_update_ctrl #(
  parameter int IDX_W      = $clog2(`SAT_TABLE_SIZE),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  upht_update_ctrl_if.slave upd
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [IDX_W-1:0] idx_q [FIFO_DEPTH];
  logic [IDX_W-1:0] idx_d [FIFO_DEPTH];
  logic [1:0]       ctr_q [FIFO_DEPTH];
  logic [1:0]       ctr_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full, empty;
  logic             rdy, wr_vld;
  logic             push, pop, coalesce, alloc;
  logic [1:0]       new_ctr;
  logic [IDX_W-1:0] wr_addr;
  logic [1:0]       wr_ctr;
`ifdef UPHT_UPD_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
`endif

  // 2-bit saturating counter step in the resolved direction
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else       return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Occupancy flags, handshakes and the merge decision
  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    // Ready never depends on a same-cycle pop, so a full buffer stays closed
    rdy     = i_rstn & ~full;
    wr_vld  = i_rstn & ~empty & upd.i_uPht_enable;
    push    = upd.i_resolve_vld & rdy;
    pop     = wr_vld;
    new_ctr = sat_step(upd.i_resolve_cnt, upd.i_resolve_taken);
`ifdef UPHT_UPD_COALESCE_EN
    young_ptr = wr_ptr_q - PTR_W'(1);
    // Merge into the youngest entry unless it is the head leaving this cycle
    coalesce  = push & ~empty & (idx_q[young_ptr] == upd.i_resolve_idx)
              & ~(pop & (count_q == CNT_W'(1)));
`else
    coalesce  = 1'b0;
`endif
    alloc   = push & ~coalesce;
  end

  // Buffer next state: merge in place or allocate at the tail; retire the head on a write
  always_comb begin
    idx_d    = idx_q;
    ctr_d    = ctr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
`ifdef UPHT_UPD_COALESCE_EN
    if (coalesce) begin
      ctr_d[young_ptr] = sat_step(ctr_q[young_ptr], upd.i_resolve_taken);
    end
`endif
    if (alloc) begin
      idx_d[wr_ptr_q] = upd.i_resolve_idx;
      ctr_d[wr_ptr_q] = new_ctr;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  // State registers; reset drops every buffered update
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ctr_q    <= ctr_d;
    end
  end

  // Write port driven from the head entry, zero when nothing is buffered
  always_comb begin
    wr_addr = '0;
    wr_ctr  = '0;
    if (i_rstn & ~empty) begin
      wr_addr = idx_q[rd_ptr_q];
      wr_ctr  = ctr_q[rd_ptr_q];
    end
  end

  assign upd.o_resolve_rdy   = rdy;
  assign upd.o_uPhtWrite_vld = wr_vld;
  assign upd.o_uPhtWr_addr   = wr_addr;
  assign upd.o_commit_Cnt    = wr_ctr;
  assign upd.o_fifo_cnt      = i_rstn ? count_q : '0;

endmodule

// File: tb/tb_upht_update_ctrl.sv
// tb/tb_upht_update_ctrl.sv - bench for upht_update_ctrl with queue model and directed vectors
`ifndef SAT_TABLE_SIZE
`define SAT_TABLE_SIZE 64
`endif

module tb_upht_update_ctrl;
  localparam int IDX_W = $clog2(`SAT_TABLE_SIZE);
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  upht_update_ctrl_if #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) bus ();

  upht_update_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .upd   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered updates as a plain queue of {index, counter}
  typedef struct {
    int idx;
    int cnt;
  } ent_t;
  ent_t mq[$];

  function automatic int sat(input int c, input int t);
    if (t != 0) return (c >= 3) ? 3 : c + 1;
    else        return (c <= 0) ? 0 : c - 1;
  endfunction

  // Model state advance at each clock edge
  always @(posedge clk) begin
    bit   m_pop, m_push, m_coal;
    ent_t e;
    if (!rstn) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && bus.i_uPht_enable;
      m_push = bus.i_resolve_vld && (mq.size() < DEPTH);
      m_coal = 1'b0;
`ifdef UPHT_UPD_COALESCE_EN
      if (m_push && mq.size() > 0 && mq[mq.size()-1].idx == int'(bus.i_resolve_idx)
          && !(m_pop && mq.size() == 1)) begin
        m_coal = 1'b1;
        mq[mq.size()-1].cnt = sat(mq[mq.size()-1].cnt, int'(bus.i_resolve_taken));
      end
`endif
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_coal) begin
        e.idx = int'(bus.i_resolve_idx);
        e.cnt = sat(int'(bus.i_resolve_cnt), int'(bus.i_resolve_taken));
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    int e_vld, e_addr, e_cnt, e_occ, e_rdy;
    e_vld  = (rstn && mq.size() > 0 && bus.i_uPht_enable) ? 1 : 0;
    e_addr = (rstn && mq.size() > 0) ? mq[0].idx : 0;
    e_cnt  = (rstn && mq.size() > 0) ? mq[0].cnt : 0;
    e_occ  = rstn ? mq.size() : 0;
    e_rdy  = (rstn && mq.size() < DEPTH) ? 1 : 0;
    check("model wr_vld",   int'(bus.o_uPhtWrite_vld), e_vld);
    check("model wr_addr",  int'(bus.o_uPhtWr_addr),   e_addr);
    check("model wr_cnt",   int'(bus.o_commit_Cnt),    e_cnt);
    check("model fifo_cnt", int'(bus.o_fifo_cnt),      e_occ);
    check("model rdy",      int'(bus.o_resolve_rdy),   e_rdy);
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int idx, input int t, input int c);
    bus.i_resolve_vld   = 1'(v);
    bus.i_resolve_idx   = IDX_W'(idx);
    bus.i_resolve_taken = 1'(t);
    bus.i_resolve_cnt   = 2'(c);
  endtask

  task automatic lit_wr(input string name, input int vld, input int addr, input int cnt);
    check({name, " vld"},  int'(bus.o_uPhtWrite_vld), vld);
    check({name, " addr"}, int'(bus.o_uPhtWr_addr),   addr);
    check({name, " cnt"},  int'(bus.o_commit_Cnt),    cnt);
  endtask

  int tv_vld[16] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int tv_idx[16] = '{3, 3, 4, 4, 4, 0, 9, 9, 9, 2, 2, 2, 0, 0, 0, 0};
  int tv_tkn[16] = '{1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int tv_cnt[16] = '{0, 0, 3, 3, 1, 0, 2, 2, 1, 3, 3, 0, 0, 0, 0, 0};
  int tv_en [16] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    rstn = 1'b0;
    bus.i_uPht_enable = 1'b1;
    drive(1, 0, 0, 0);

    // Reset held three cycles with a valid record presented
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst rdy",      int'(bus.o_resolve_rdy),   0);
      check("rst wr_vld",   int'(bus.o_uPhtWrite_vld), 0);
      check("rst fifo_cnt", int'(bus.o_fifo_cnt),      0);
      adv();
    end
    rstn = 1'b1;
    drive(0, 0, 0, 0);

    // Single record: one cycle of latency, then the write port drains it
    drive(1, 5, 1, 1);
    @(negedge clk);
    check("t2 rdy", int'(bus.o_resolve_rdy), 1);
    lit_wr("t2 pre", 0, 0, 0);
    adv();
    drive(0, 0, 0, 0);
    @(negedge clk);
    lit_wr("t2 wr", 1, 5, 2);
    check("t2 fifo_cnt", int'(bus.o_fifo_cnt), 1);
    adv();
    @(negedge clk);
    check("t2 idle vld", int'(bus.o_uPhtWrite_vld), 0);
    adv();

    // Saturation at both ends and a plain decrement, back to back
    drive(1, 10, 1, 3);
    adv();
    drive(1, 11, 0, 0);
    @(negedge clk);
    lit_wr("t3 sat hi", 1, 10, 3);
    adv();
    drive(1, 12, 0, 2);
    @(negedge clk);
    lit_wr("t3 sat lo", 1, 11, 0);
    check("t3 fifo_cnt", int'(bus.o_fifo_cnt), 1);
    adv();
    drive(0, 0, 0, 0);
    @(negedge clk);
    lit_wr("t3 dec", 1, 12, 1);
    adv();

    // Fill with the uPHT disabled, then drain in order
    bus.i_uPht_enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 0, 2);
      adv();
    end
    drive(1, 9, 1, 1);
    @(negedge clk);
    check("t4 full rdy",  int'(bus.o_resolve_rdy),   0);
    check("t4 full occ",  int'(bus.o_fifo_cnt),      4);
    check("t4 full vld",  int'(bus.o_uPhtWrite_vld), 0);
    adv();
    drive(0, 0, 0, 0);
    bus.i_uPht_enable = 1'b1;
    @(negedge clk);
    lit_wr("t4 w1", 1, 1, 1);
    check("t4 w1 rdy", int'(bus.o_resolve_rdy), 0);
    adv();
    @(negedge clk);
    lit_wr("t4 w2", 1, 2, 1);
    check("t4 w2 rdy", int'(bus.o_resolve_rdy), 1);
    adv();
    @(negedge clk);
    lit_wr("t4 w3", 1, 3, 1);
    adv();
    @(negedge clk);
    lit_wr("t4 w4", 1, 4, 1);
    adv();
    @(negedge clk);
    check("t4 drained", int'(bus.o_fifo_cnt), 0);
    adv();

    // Same index twice while the uPHT is disabled
    bus.i_uPht_enable = 1'b0;
    drive(1, 7, 1, 1);
    adv();
    adv();
    drive(0, 0, 0, 0);
    @(negedge clk);
`ifdef UPHT_UPD_COALESCE_EN
    check("t5 occ", int'(bus.o_fifo_cnt), 1);
`else
    check("t5 occ", int'(bus.o_fifo_cnt), 2);
`endif
    adv();
    bus.i_uPht_enable = 1'b1;
    @(negedge clk);
`ifdef UPHT_UPD_COALESCE_EN
    lit_wr("t5 w1", 1, 7, 3);
    adv();
    @(negedge clk);
    check("t5 after", int'(bus.o_uPhtWrite_vld), 0);
`else
    lit_wr("t5 w1", 1, 7, 2);
    adv();
    @(negedge clk);
    lit_wr("t5 w2", 1, 7, 2);
`endif
    adv();
    adv();

    // Reset with two buffered entries drops them
    bus.i_uPht_enable = 1'b0;
    drive(1, 3, 1, 0);
    adv();
    drive(1, 4, 1, 0);
    adv();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t6 occ", int'(bus.o_fifo_cnt), 2);
    adv();
    rstn = 1'b0;
    @(negedge clk);
    check("t6 in rst rdy", int'(bus.o_resolve_rdy), 0);
    adv();
    rstn = 1'b1;
    bus.i_uPht_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6 post vld", int'(bus.o_uPhtWrite_vld), 0);
      check("t6 post occ", int'(bus.o_fifo_cnt),      0);
      adv();
    end

    // Same index arriving while the single head entry is leaving
    drive(1, 20, 1, 1);
    adv();
    drive(1, 20, 1, 1);
    @(negedge clk);
    lit_wr("t7 w1", 1, 20, 2);
    adv();
    drive(0, 0, 0, 0);
    @(negedge clk);
    lit_wr("t7 w2", 1, 20, 2);
    adv();
    @(negedge clk);
    check("t7 idle", int'(bus.o_uPhtWrite_vld), 0);
    adv();

    // Mixed directed traffic checked by the model only
    for (int i = 0; i < 16; i++) begin
      drive(tv_vld[i], tv_idx[i], tv_tkn[i], tv_cnt[i]);
      bus.i_uPht_enable = 1'(tv_en[i]);
      adv();
    end
    drive(0, 0, 0, 0);
    bus.i_uPht_enable = 1'b1;
    repeat (6) adv();
    @(negedge clk);
    check("end occ", int'(bus.o_fifo_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
